// File: rtl/bist_response_analyzer.sv
// bist_response_analyzer
//   Compares memory read data against golden data under a bit mask while a
//   test is running, and keeps a summary of the failures for readout.
//
//   Ports
//     CLK             : clock, all state on rising edge
//     RST_N           : asynchronous active-low reset
//     START           : pulse, clears results and enters RUN (ignored in RUN)
//     STOP            : pulse, RUN -> DONE (ignored outside RUN)
//     CMP_VALID       : qualifies CMP_ADDR/DATA/EXPECTED/MASK
//     CMP_ADDR        : address of the current beat
//     DATA            : read data from the memory under test
//     EXPECTED        : golden data
//     MASK            : 1 = bit compared, 0 = bit ignored
//     BUSY            : high in RUN
//     DONE            : high in DONE
//     MISMATCH        : one-cycle flag, previous beat failed
//     PASS            : verdict, meaningful while DONE=1
//     FAIL_COUNT      : number of failing beats, saturating
//     FIRST_FAIL_ADDR : CMP_ADDR of the first failing beat
//     FIRST_FAIL_DATA : DATA of the first failing beat
//     ERR_BITS        : sticky OR of masked bit errors
module bist_response_analyzer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  CMP_VALID,
  input  logic [ADDR_WIDTH-1:0] CMP_ADDR,
  input  logic [DATA_WIDTH-1:0] DATA,
  input  logic [DATA_WIDTH-1:0] EXPECTED,
  input  logic [DATA_WIDTH-1:0] MASK,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  MISMATCH,
  output logic                  PASS,
  output logic [CNT_WIDTH-1:0]  FAIL_COUNT,
  output logic [ADDR_WIDTH-1:0] FIRST_FAIL_ADDR,
  output logic [DATA_WIDTH-1:0] FIRST_FAIL_DATA,
  output logic [DATA_WIDTH-1:0] ERR_BITS
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                  r_busy;
  logic                  r_done;
  logic                  r_mismatch;
  logic                  r_pass;
  logic [CNT_WIDTH-1:0]  r_fail_count;
  logic [ADDR_WIDTH-1:0] r_ff_addr;
  logic [DATA_WIDTH-1:0] r_ff_data;
  logic [DATA_WIDTH-1:0] r_err_bits;

  logic [DATA_WIDTH-1:0] w_err;
  logic                  w_beat;
  logic                  w_fail;
  logic                  w_start;
  logic                  w_stop;
  logic                  w_cnt_sat;

  assign w_err     = (DATA ^ EXPECTED) & MASK;
  assign w_beat    = CMP_VALID && (r_state == S_RUN);
  assign w_fail    = w_beat && (|w_err);
  assign w_start   = START && (r_state != S_RUN);
  assign w_stop    = STOP && (r_state == S_RUN);
  assign w_cnt_sat = &r_fail_count;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (START) w_state_nxt = S_RUN;
      S_RUN:   if (STOP)  w_state_nxt = S_DONE;
      S_DONE:  if (START) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mismatch   <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_count <= '0;
      r_ff_addr    <= '0;
      r_ff_data    <= '0;
      r_err_bits   <= '0;
    end else begin
      // Status flags track the state being entered so they stay registered.
      r_busy     <= (w_state_nxt == S_RUN);
      r_done     <= (w_state_nxt == S_DONE);
      r_mismatch <= w_fail;
      if (w_start) begin
        r_pass       <= 1'b0;
        r_fail_count <= '0;
        r_ff_addr    <= '0;
        r_ff_data    <= '0;
        r_err_bits   <= '0;
      end else begin
        if (w_fail) begin
          // A zero count means no earlier failure; the count never returns
          // to zero once it has moved, even when saturated.
          if (r_fail_count == '0) begin
            r_ff_addr <= CMP_ADDR;
            r_ff_data <= DATA;
          end
          if (!w_cnt_sat) r_fail_count <= r_fail_count + 1'b1;
          r_err_bits <= r_err_bits | w_err;
        end
        // Verdict folds in a failing beat sampled with STOP.
        if (w_stop) r_pass <= (r_fail_count == '0) && !w_fail;
      end
    end
  end

  assign BUSY            = r_busy;
  assign DONE            = r_done;
  assign MISMATCH        = r_mismatch;
  assign PASS            = r_pass;
  assign FAIL_COUNT      = r_fail_count;
  assign FIRST_FAIL_ADDR = r_ff_addr;
  assign FIRST_FAIL_DATA = r_ff_data;
  assign ERR_BITS        = r_err_bits;

endmodule
